computie_bus_target: RTL and testbench
======================================

// Module: computie_bus_target
//
// PURPOSE
// - Parametrised Computie bus target (slave) controller; next generation of the simple receive-only bus controller.
// - Sits between the external multiplexed Computie bus (via transceivers and demux) and one internal peripheral.
// - Adds the following over the previous generation:
//   - address decode;
//   - 68k-style transfer sizing with byte-lane enables;
//   - a req/ack internal handshake with wait states;
//   - DSACK/BERR termination and a bus-error timeout;
//   - input synchronisers.
//
// PARAMETERS
// - BITWIDTH     32            bus/data width; 16 or 32 only. LANES = BITWIDTH/8.
// - BASE_ADDR    32'h0020_0000 decode base address.
// - ADDR_MASK    32'hFFF0_0000 decode mask. Match when (addr & ADDR_MASK) == BASE_ADDR.
// - TIMEOUT      16            cycles in ACCESS without ack before BERR; range 2..255.
// - DSACK_CODE   2'b00         active-low DSACK value driven on termination (00=32-bit port, 01=16-bit port).
//
// PORTS
// - clk           in   1         system clock.
// - reset         in   1         synchronous, active-high reset.
// - addr_strobe   in   1         bus /AS, active low, asynchronous to clk.
// - data_strobe   in   1         bus /DS, active low, asynchronous to clk.
// - read_write    in   1         1 = bus reads from this device.
// - size          in   2         68k SIZ: 00=long, 01=byte, 10=word, 11=3-byte.
// - dsack_out     out  2         /DSACK1:0, active low. Idle 2'b11.
// - berr_out      out  1         /BERR, active low. Idle 1.
// - send_receive  out  1         transceiver direction; constant 0 (receive).
// - addr_oe       out  1         address transceiver enable.
// - data_oe       out  1         data transceiver enable.
// - data_dir      out  1         1 = drive data onto bus (read cycle).
// - demux_oe      out  1         demux enable; 1 while a matched cycle is in progress.
// - from_bus      in   BITWIDTH  demuxed bus input.
// - to_bus        out  BITWIDTH  data driven to bus on reads.
// - req           out  1         internal access request; held until ack or abort.
// - ack           in   1         internal access complete. Read data on data_in is valid in the same cycle.
// - write         out  1         internal direction, ~read_write latched.
// - addr_out      out  BITWIDTH  latched address.
// - byte_en       out  LANES     lane enables; MSB = lane at offset 0 (big-endian).
// - data_out      out  BITWIDTH  write data to peripheral.
// - data_in       in   BITWIDTH  read data from peripheral.
//
// BEHAVIOUR
// - Reset:
//   - state = IDLE;
//   - dsack_out = 2'b11, berr_out = 1;
//   - addr_oe, data_oe, data_dir, demux_oe, req, write = 0;
//   - addr_out, data_out, to_bus, byte_en = 0;
//   - timeout counter = 0.
//   - Reset mid-cycle forces all of the above on the next edge, regardless of strobes.
// - addr_strobe and data_strobe pass through 2-FF synchronisers (as_s, ds_s). All FSM decisions use the synchronised values.
// - IDLE:
//   - as_s == 0 -> ADDR.
//   - addr_oe = 1 is asserted on entry to ADDR.
// - ADDR (1 cycle):
//   - Latch from_bus -> addr_out, size, and write = ~read_write.
//   - Compute byte_en.
//   - If the address matches -> WAIT_DS with demux_oe = 1; otherwise -> IGNORE.
// - IGNORE:
//   - All outputs idle.
//   - as_s == 1 -> IDLE.
//   - Never drives dsack_out or berr_out.
// - WAIT_DS:
//   - addr_oe = 0, data_oe = 1, data_dir = read_write.
//   - On ds_s == 0: latch from_bus -> data_out (writes only), assert req, clear the counter -> ACCESS.
// - ACCESS:
//   - req held high; the counter increments each cycle.
//   - ack -> req = 0. On reads, data_in -> to_bus. dsack_out = DSACK_CODE in the next cycle -> TERM.
//   - counter == TIMEOUT-1 with no ack -> req = 0, berr_out = 0 -> TERM.
//   - ack and timeout in the same cycle: ack wins (normal termination).
// - TERM:
//   - Hold dsack_out/berr_out until as_s == 1.
//   - Then release all bus outputs to idle -> IDLE.
// - Abort: as_s == 1 in WAIT_DS or ACCESS:
//   - drop req, data_oe and demux_oe -> IDLE;
//   - no DSACK or BERR is driven;
//   - an ack in the abort cycle, or any later ack, is ignored.
// - byte_en:
//   - off = addr[log2(LANES)-1:0]; n = (size == 0) ? 4 : size.
//   - Lane i (offset i) is enabled iff off <= i < off + n, with i < LANES. Misaligned overrun is truncated at the port edge.
// - ack outside ACCESS is ignored.
// - Best-case latency, AS low to DSACK low, with ack tied high: 6 clk.
//   - 2 sync, ADDR, WAIT_DS (DS already low), ACCESS, TERM register.
//
// STRUCTURE
// - computie_bus_pkg: state enum, SIZ encodings, DSACK codes (DSACK_32 = 2'b00, DSACK_16 = 2'b01, DSACK_NONE = 2'b11).
// - Sub-module computie_bus_byte_enables: combinational size/offset -> byte_en, parametrised on LANES.
// - Synchronisers are inline.
//
// TESTING
// - Long write: addr 0x0020_0010, size 00, data 0xDEADBEEF, ack 3 cycles after req.
//   -> data_out = 0xDEADBEEF, byte_en = 1111, write = 1, dsack_out = 00 until AS high.
// - Byte read: addr 0x0020_0003, size 01, data_in = 0x000000A5 at ack.
//   -> byte_en = 0001, to_bus = 0x000000A5, data_dir = 1.
// - Miss: addr 0x0030_0000.
//   -> no req, dsack_out = 11, berr_out = 1 throughout, returns to IDLE after AS high.
// - Timeout: TIMEOUT = 16, ack held low.
//   -> berr_out = 0 exactly 16 cycles after req rose; req = 0; released on AS high.
// - Abort and reset: AS deasserted 2 cycles into ACCESS, then late ack.
//   -> no DSACK. A separate reset mid-ACCESS returns all outputs to reset values next edge.
// - Word at offset 3 on BITWIDTH = 32 (size 10) -> byte_en = 0001 (truncated).

Source files
------------

// File: rtl/computie_bus_pkg.sv
// Shared types and encodings for the Computie bus target controller.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_IGNORE, ST_WAIT_DS, ST_ACCESS, ST_TERM
  } state_t;

  typedef enum logic [1:0] {
    SIZ_LONG  = 2'b00,
    SIZ_BYTE  = 2'b01,
    SIZ_WORD  = 2'b10,
    SIZ_3BYTE = 2'b11
  } siz_t;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Bytes moved by a 68k SIZ code; 00 encodes a long (4 bytes).
  function automatic int siz_bytes(input logic [1:0] siz);
    return (siz == SIZ_LONG) ? 4 : int'(siz);
  endfunction

endpackage

// File: rtl/computie_bus_byte_enables.sv
// Combinational size/offset to big-endian byte-lane enables.
module computie_bus_byte_enables
  import computie_bus_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int OFFW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [OFFW-1:0]  off,
  input  logic [1:0]       size,
  output logic [LANES-1:0] byte_en
);

  // Lane i sits at bit LANES-1-i; lanes past the port edge simply never exist.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign byte_en[LANES-1-i] = (int'(off) <= i) && (i < int'(off) + siz_bytes(size));
  end

endmodule

// File: rtl/computie_bus_target.sv
// Computie bus target: decode, sized transfers, req/ack to one peripheral, DSACK/BERR termination.
module computie_bus_target
  import computie_bus_pkg::*;
#(
  parameter int          BITWIDTH   = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0020_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFF0_0000,
  parameter int          TIMEOUT    = 16,
  parameter logic [1:0]  DSACK_CODE = DSACK_32,
  localparam int         LANES      = BITWIDTH / 8,
  localparam int         OFFW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                addr_strobe,
  input  logic                data_strobe,
  input  logic                read_write,
  input  logic [1:0]          size,
  output logic [1:0]          dsack_out,
  output logic                berr_out,
  output logic                send_receive,
  output logic                addr_oe,
  output logic                data_oe,
  output logic                data_dir,
  output logic                demux_oe,
  input  logic [BITWIDTH-1:0] from_bus,
  output logic [BITWIDTH-1:0] to_bus,
  output logic                req,
  input  logic                ack,
  output logic                write,
  output logic [BITWIDTH-1:0] addr_out,
  output logic [LANES-1:0]    byte_en,
  output logic [BITWIDTH-1:0] data_out,
  input  logic [BITWIDTH-1:0] data_in
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic             as_meta, as_s, ds_meta, ds_s;
  logic [7:0]       cnt;
  logic [31:0]      addr32;
  logic             hit;
  logic [LANES-1:0] be_next;

  assign send_receive = 1'b0;
  assign addr32       = 32'(from_bus);
  assign hit          = (addr32 & ADDR_MASK) == BASE_ADDR;

  computie_bus_byte_enables #(.LANES(LANES)) u_be (
    .off     (from_bus[OFFW-1:0]),
    .size    (size),
    .byte_en (be_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      as_meta   <= 1'b1;
      as_s      <= 1'b1;
      ds_meta   <= 1'b1;
      ds_s      <= 1'b1;
      state     <= ST_IDLE;
      dsack_out <= DSACK_NONE;
      berr_out  <= 1'b1;
      addr_oe   <= 1'b0;
      data_oe   <= 1'b0;
      data_dir  <= 1'b0;
      demux_oe  <= 1'b0;
      req       <= 1'b0;
      write     <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      to_bus    <= '0;
      byte_en   <= '0;
      cnt       <= '0;
    end else begin
      as_meta <= addr_strobe;
      as_s    <= as_meta;
      ds_meta <= data_strobe;
      ds_s    <= ds_meta;
      case (state)
        ST_IDLE: if (!as_s) begin
          addr_oe <= 1'b1;
          state   <= ST_ADDR;
        end
        ST_ADDR: begin
          addr_out <= from_bus;
          write    <= ~read_write;
          byte_en  <= be_next;
          addr_oe  <= 1'b0;
          if (hit) begin
            demux_oe <= 1'b1;
            data_oe  <= 1'b1;
            data_dir <= read_write;
            state    <= ST_WAIT_DS;
          end else begin
            state <= ST_IGNORE;
          end
        end
        ST_IGNORE: if (as_s) state <= ST_IDLE;
        ST_WAIT_DS: begin
          if (as_s) begin
            data_oe  <= 1'b0;
            demux_oe <= 1'b0;
            data_dir <= 1'b0;
            state    <= ST_IDLE;
          end else if (!ds_s) begin
            if (write) data_out <= from_bus;
            req   <= 1'b1;
            cnt   <= '0;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Master walking away beats a same-cycle ack: no termination is driven.
          if (as_s) begin
            req      <= 1'b0;
            data_oe  <= 1'b0;
            demux_oe <= 1'b0;
            data_dir <= 1'b0;
            state    <= ST_IDLE;
          end else if (ack) begin
            req       <= 1'b0;
            if (!write) to_bus <= data_in;
            dsack_out <= DSACK_CODE;
            state     <= ST_TERM;
          end else if (cnt == TO_LAST) begin
            req      <= 1'b0;
            berr_out <= 1'b0;
            state    <= ST_TERM;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_TERM: if (as_s) begin
          dsack_out <= DSACK_NONE;
          berr_out  <= 1'b1;
          data_oe   <= 1'b0;
          demux_oe  <= 1'b0;
          data_dir  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_computie_bus_target.sv
// Directed bench for computie_bus_target with default parameters (32-bit, TIMEOUT 16).
module tb_computie_bus_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        addr_strobe, data_strobe, read_write;
  logic [1:0]  size;
  logic [1:0]  dsack_out;
  logic        berr_out, send_receive, addr_oe, data_oe, data_dir, demux_oe;
  logic [31:0] from_bus, to_bus, addr_out, data_out, data_in;
  logic        req, ack, write;
  logic [3:0]  byte_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  computie_bus_target dut (
    .clk(clk), .reset(reset), .addr_strobe(addr_strobe), .data_strobe(data_strobe),
    .read_write(read_write), .size(size), .dsack_out(dsack_out), .berr_out(berr_out),
    .send_receive(send_receive), .addr_oe(addr_oe), .data_oe(data_oe), .data_dir(data_dir),
    .demux_oe(demux_oe), .from_bus(from_bus), .to_bus(to_bus), .req(req), .ack(ack),
    .write(write), .addr_out(addr_out), .byte_en(byte_en), .data_out(data_out),
    .data_in(data_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobes fall together at a negedge; cyc(k) afterwards lands just after edge k.
  task automatic start(input logic [31:0] a, input logic rw, input logic [1:0] s);
    from_bus    = a;
    read_write  = rw;
    size        = s;
    addr_strobe = 1'b0;
    data_strobe = 1'b0;
  endtask

  task automatic release_bus();
    addr_strobe = 1'b1;
    data_strobe = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr_strobe = 1'b1; data_strobe = 1'b1; read_write = 1'b0;
    size = 2'b00; from_bus = '0; data_in = '0; ack = 1'b0;
    cyc(3);
    chk("rst_dsack", 32'(dsack_out), 32'h3);
    chk("rst_berr",  32'(berr_out), 32'h1);
    chk("rst_oe",    {28'h0, addr_oe, data_oe, data_dir, demux_oe}, 32'h0);
    chk("rst_req_wr", {30'h0, req, write}, 32'h0);
    chk("rst_be",    32'(byte_en), 32'h0);
    chk("rst_sr",    32'(send_receive), 32'h0);
    reset = 1'b0;
    cyc(2);

    // Long write, ack three cycles after req.
    start(32'h0020_0010, 1'b0, 2'b00);
    cyc(4);
    from_bus = 32'hDEAD_BEEF;
    cyc(1);
    chk("lw_req",     32'(req), 32'h1);
    chk("lw_data",    data_out, 32'hDEAD_BEEF);
    chk("lw_addr",    addr_out, 32'h0020_0010);
    chk("lw_be",      32'(byte_en), 32'hF);
    chk("lw_write",   32'(write), 32'h1);
    chk("lw_oe",      {28'h0, addr_oe, data_oe, data_dir, demux_oe}, 32'h5);
    cyc(2);
    chk("lw_dsack_pre", 32'(dsack_out), 32'h3);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("lw_dsack",   32'(dsack_out), 32'h0);
    chk("lw_req_off", 32'(req), 32'h0);
    cyc(3);
    chk("lw_dsack_hold", 32'(dsack_out), 32'h0);
    release_bus();
    cyc(2);
    chk("lw_dsack_sync", 32'(dsack_out), 32'h0);
    cyc(1);
    chk("lw_dsack_rel", 32'(dsack_out), 32'h3);
    chk("lw_oe_rel",  {28'h0, addr_oe, data_oe, data_dir, demux_oe}, 32'h0);
    cyc(2);

    // Byte read with ack tied high: also the 6-clock best-case latency.
    data_in = 32'h0000_00A5;
    ack = 1'b1;
    start(32'h0020_0003, 1'b1, 2'b01);
    cyc(5);
    chk("br_dsack_5", 32'(dsack_out), 32'h3);
    chk("br_be",      32'(byte_en), 32'h1);
    chk("br_dir",     32'(data_dir), 32'h1);
    cyc(1);
    chk("br_dsack_6", 32'(dsack_out), 32'h0);
    chk("br_to_bus",  to_bus, 32'h0000_00A5);
    chk("br_write",   32'(write), 32'h0);
    ack = 1'b0;
    release_bus();
    cyc(3);
    chk("br_dsack_rel", 32'(dsack_out), 32'h3);
    cyc(2);

    // Address miss: nothing driven for the whole cycle.
    start(32'h0030_0000, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("miss_req",   32'(req), 32'h0);
      chk("miss_term",  {29'h0, dsack_out, berr_out}, 32'h7);
      chk("miss_demux", 32'(demux_oe), 32'h0);
    end
    release_bus();
    cyc(4);

    // Timeout: word read, ack never arrives.
    start(32'h0020_0000, 1'b1, 2'b10);
    cyc(5);
    chk("to_req",  32'(req), 32'h1);
    chk("to_be",   32'(byte_en), 32'hC);
    cyc(15);
    chk("to_berr_15", 32'(berr_out), 32'h1);
    chk("to_req_15",  32'(req), 32'h1);
    cyc(1);
    chk("to_berr_16", 32'(berr_out), 32'h0);
    chk("to_req_16",  32'(req), 32'h0);
    chk("to_dsack",   32'(dsack_out), 32'h3);
    release_bus();
    cyc(2);
    chk("to_berr_hold", 32'(berr_out), 32'h0);
    cyc(1);
    chk("to_berr_rel", 32'(berr_out), 32'h1);
    cyc(2);

    // Abort two cycles into ACCESS, ack arriving in the abort cycle and after.
    start(32'h0020_0004, 1'b0, 2'b00);
    cyc(4);
    from_bus = 32'h1234_5678;
    cyc(2);
    release_bus();
    cyc(2);
    chk("ab_req_hold", 32'(req), 32'h1);
    ack = 1'b1;
    cyc(1);
    chk("ab_req",   32'(req), 32'h0);
    chk("ab_oe",    {30'h0, data_oe, demux_oe}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("ab_term", {29'h0, dsack_out, berr_out}, 32'h7);
    end
    ack = 1'b0;
    cyc(2);

    // Word at offset 3 truncates to one lane; 3-byte at offset 1 fills the rest.
    ack = 1'b1;
    data_in = 32'h0000_0042;
    start(32'h0020_0003, 1'b1, 2'b10);
    cyc(6);
    chk("w3_be",    32'(byte_en), 32'h1);
    chk("w3_dsack", 32'(dsack_out), 32'h0);
    release_bus();
    cyc(4);
    start(32'h0020_0001, 1'b1, 2'b11);
    cyc(6);
    chk("t1_be",     32'(byte_en), 32'h7);
    chk("t1_to_bus", to_bus, 32'h0000_0042);
    ack = 1'b0;
    release_bus();
    cyc(4);

    // Reset in the middle of ACCESS.
    start(32'h0020_0008, 1'b0, 2'b01);
    cyc(4);
    from_bus = 32'hCAFE_F00D;
    cyc(2);
    chk("rs_req_pre", 32'(req), 32'h1);
    reset = 1'b1;
    release_bus();
    cyc(1);
    chk("rs_dsack", 32'(dsack_out), 32'h3);
    chk("rs_berr",  32'(berr_out), 32'h1);
    chk("rs_oe",    {28'h0, addr_oe, data_oe, data_dir, demux_oe}, 32'h0);
    chk("rs_req_wr", {30'h0, req, write}, 32'h0);
    chk("rs_addr",  addr_out, 32'h0);
    chk("rs_data",  data_out, 32'h0);
    chk("rs_to_bus", to_bus, 32'h0);
    chk("rs_be",    32'(byte_en), 32'h0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    chk("rs_idle_req", 32'(req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
